// File: rtl/shift_sipo_rx.sv
// Serial-to-parallel frame receiver: reassembles start-framed serial bits into
// WIDTH-bit words and hands them over through a one-entry valid/ready slot.
module shift_sipo_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             shift_reg_clk,
    input  logic             shift_reg_rst_n,
    input  logic             shift_rx_sin,
    input  logic             shift_rx_sin_vld,
    input  logic             shift_rx_start,
    input  logic             shift_rx_dout_rdy,
    input  logic             shift_rx_ovf_clr,
    output logic [WIDTH-1:0] shift_rx_dout,
    output logic             shift_rx_dout_vld,
    output logic             shift_rx_busy,
    output logic             shift_rx_ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] sr_cap;
    logic             word_done;

    // Shift register contents with the current serial bit applied
    function automatic logic [WIDTH-1:0] capture(input logic [WIDTH-1:0] sr,
                                                  input logic             b);
        if (MSB_FIRST) begin
            return {sr[WIDTH-2:0], b};
        end else begin
            return {b, sr[WIDTH-1:1]};
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        vld_d     = vld_q;
        ovf_d     = ovf_q;
        word_done = 1'b0;
        sr_cap    = capture(sr_q, shift_rx_sin);

        if (vld_q && shift_rx_dout_rdy) begin
            vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (shift_rx_sin_vld && shift_rx_start) begin
                    sr_d    = sr_cap;
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_rx_sin_vld) begin
                    sr_d = sr_cap;
                    if (shift_rx_start) begin
                        // Resync: the start bit becomes bit 0 of a fresh word
                        cnt_d = CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        state_d   = IDLE;
                        word_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (shift_rx_ovf_clr) begin
            ovf_d = 1'b0;
        end

        // Delivery into the holding slot; a drop sets overflow over a clear
        if (word_done) begin
            if (!vld_q || shift_rx_dout_rdy) begin
                dout_d = sr_cap;
                vld_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge shift_reg_clk or negedge shift_reg_rst_n) begin
        if (!shift_reg_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign shift_rx_dout     = dout_q;
    assign shift_rx_dout_vld = vld_q;
    assign shift_rx_busy     = busy_q;
    assign shift_rx_ovf      = ovf_q;

endmodule

// File: tb/tb_shift_sipo_rx.sv
// Bench for shift_sipo_rx: MSB-first and LSB-first instances, expected words
// queued at stimulus time and checked when a word is handed over.
module tb_shift_sipo_rx;

    logic clk;
    logic rst_n;

    logic       m_sin, m_sin_vld, m_start, m_rdy, m_clr;
    logic [3:0] m_dout;
    logic       m_dout_vld, m_busy, m_ovf;

    logic       l_sin, l_sin_vld, l_start, l_rdy, l_clr;
    logic [3:0] l_dout;
    logic       l_dout_vld, l_busy, l_ovf;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_m[$];
    logic [3:0] exp_l[$];

    shift_sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .shift_reg_clk     (clk),
        .shift_reg_rst_n   (rst_n),
        .shift_rx_sin      (m_sin),
        .shift_rx_sin_vld  (m_sin_vld),
        .shift_rx_start    (m_start),
        .shift_rx_dout_rdy (m_rdy),
        .shift_rx_ovf_clr  (m_clr),
        .shift_rx_dout     (m_dout),
        .shift_rx_dout_vld (m_dout_vld),
        .shift_rx_busy     (m_busy),
        .shift_rx_ovf      (m_ovf)
    );

    shift_sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .shift_reg_clk     (clk),
        .shift_reg_rst_n   (rst_n),
        .shift_rx_sin      (l_sin),
        .shift_rx_sin_vld  (l_sin_vld),
        .shift_rx_start    (l_start),
        .shift_rx_dout_rdy (l_rdy),
        .shift_rx_ovf_clr  (l_clr),
        .shift_rx_dout     (l_dout),
        .shift_rx_dout_vld (l_dout_vld),
        .shift_rx_busy     (l_busy),
        .shift_rx_ovf      (l_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handover (vld && rdy) must match the oldest expected word
    always @(negedge clk) begin
        if (m_dout_vld && m_rdy) begin
            checks++;
            if (exp_m.size() == 0) begin
                failures++;
                $display("FAIL msb_word unexpected word got=%b", m_dout);
            end else begin
                logic [3:0] e;
                e = exp_m.pop_front();
                if (m_dout !== e) begin
                    failures++;
                    $display("FAIL msb_word got=%b exp=%b", m_dout, e);
                end
            end
        end
        if (l_dout_vld && l_rdy) begin
            checks++;
            if (exp_l.size() == 0) begin
                failures++;
                $display("FAIL lsb_word unexpected word got=%b", l_dout);
            end else begin
                logic [3:0] e;
                e = exp_l.pop_front();
                if (l_dout !== e) begin
                    failures++;
                    $display("FAIL lsb_word got=%b exp=%b", l_dout, e);
                end
            end
        end
    end

    task automatic m_drive(input logic v, input logic s, input logic st);
        @(posedge clk);
        #1;
        m_sin_vld = v;
        m_sin     = s;
        m_start   = st;
    endtask

    task automatic l_drive(input logic v, input logic s, input logic st);
        @(posedge clk);
        #1;
        l_sin_vld = v;
        l_sin     = s;
        l_start   = st;
    endtask

    task automatic m_frame(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) begin
            m_drive(1'b1, w[i], i == 3);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m_sin = 0; m_sin_vld = 0; m_start = 0; m_rdy = 0; m_clr = 0;
        l_sin = 0; l_sin_vld = 0; l_start = 0; l_rdy = 0; l_clr = 0;
        #12;
        checks++;
        if ({m_dout, m_dout_vld, m_busy, m_ovf} !== 7'b0) begin
            failures++;
            $display("FAIL reset_msb got=%b exp=0000000", {m_dout, m_dout_vld, m_busy, m_ovf});
        end
        checks++;
        if ({l_dout, l_dout_vld, l_busy, l_ovf} !== 7'b0) begin
            failures++;
            $display("FAIL reset_lsb got=%b exp=0000000", {l_dout, l_dout_vld, l_busy, l_ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [3:0] bits;
        bits  = 4'b1101;
        m_rdy = 1'b1;
        exp_m.push_back(4'b1101);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) m_drive(1'b1, bits[3-i], i == 0);
            else       m_drive(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (m_busy !== (i >= 1 && i <= 3)) begin
                failures++;
                $display("FAIL basic_busy step=%0d got=%b exp=%b", i, m_busy, (i >= 1 && i <= 3));
            end
            checks++;
            if (m_dout_vld !== (i == 4)) begin
                failures++;
                $display("FAIL basic_vld step=%0d got=%b exp=%b", i, m_dout_vld, (i == 4));
            end
        end
    endtask

    task automatic test_gapped;
        logic [8:0] v_pat;
        logic [8:0] s_pat;
        // step order LSB-first in the vectors: b1, b2, gap x3, b3, b4, idle, idle
        v_pat = 9'b0_0110_0011;
        s_pat = 9'b0_0100_0011;
        m_rdy = 1'b1;
        exp_m.push_back(4'b1101);
        for (int i = 0; i < 9; i++) begin
            m_drive(v_pat[i], s_pat[i], i == 0);
            @(negedge clk);
            checks++;
            if (m_dout_vld !== (i == 7)) begin
                failures++;
                $display("FAIL gap_vld step=%0d got=%b exp=%b", i, m_dout_vld, (i == 7));
            end
        end
    endtask

    task automatic test_overflow;
        m_rdy = 1'b0;
        exp_m.push_back(4'b1010);
        m_frame(4'b1010);
        m_frame(4'b0110);
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({m_dout_vld, m_ovf, m_dout} !== 6'b11_1010) begin
            failures++;
            $display("FAIL ovf_hold got=%b exp=111010", {m_dout_vld, m_ovf, m_dout});
        end
        @(posedge clk); #1; m_rdy = 1'b1;
        @(posedge clk); #1; m_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_dout_vld, m_ovf} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_drain got=%b exp=01", {m_dout_vld, m_ovf});
        end
        @(posedge clk); #1; m_clr = 1'b1;
        @(posedge clk); #1; m_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (m_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", m_ovf);
        end
    endtask

    task automatic test_resync;
        m_rdy = 1'b1;
        exp_m.push_back(4'b0011);
        m_drive(1'b1, 1'b1, 1'b0);
        m_drive(1'b1, 1'b1, 1'b0);
        m_drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b0) begin
            failures++;
            $display("FAIL resync_unframed_busy got=%b exp=0", m_busy);
        end
        m_drive(1'b1, 1'b0, 1'b0);
        m_frame(4'b0011);
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({m_dout_vld, m_ovf, m_dout} !== 6'b10_0011) begin
            failures++;
            $display("FAIL resync_word got=%b exp=100011", {m_dout_vld, m_ovf, m_dout});
        end
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        m_rdy = 1'b0;
        m_frame(4'b1111);
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (m_dout_vld !== 1'b1) begin
            failures++;
            $display("FAIL midrst_preload got=%b exp=1", m_dout_vld);
        end
        m_drive(1'b1, 1'b1, 1'b1);
        m_drive(1'b1, 1'b0, 1'b0);
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_dout, m_dout_vld, m_busy, m_ovf} !== 7'b0) begin
            failures++;
            $display("FAIL midrst_clear got=%b exp=0000000", {m_dout, m_dout_vld, m_busy, m_ovf});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_rdy = 1'b1;
        exp_m.push_back(4'b1001);
        m_frame(4'b1001);
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({m_dout_vld, m_dout} !== 5'b1_1001) begin
            failures++;
            $display("FAIL midrst_next got=%b exp=11001", {m_dout_vld, m_dout});
        end
        m_drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bits;
        // received order, index 0 first: frame A 1,0,0,0 then frame B 0,1,1,1
        bits  = 8'b1110_0001;
        l_rdy = 1'b1;
        exp_l.push_back(4'b0001);
        exp_l.push_back(4'b1110);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) l_drive(1'b1, bits[i], (i % 4) == 0);
            else       l_drive(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (l_dout_vld !== (i == 4 || i == 8)) begin
                failures++;
                $display("FAIL b2b_vld step=%0d got=%b exp=%b", i, l_dout_vld, (i == 4 || i == 8));
            end
        end
        checks++;
        if (l_ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf got=%b exp=0", l_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_overflow();
        test_resync();
        test_reset_midframe();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending msb=%0d lsb=%0d exp=0", exp_m.size(), exp_l.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sipo_rx.md
# shift_sipo_rx

Serial-to-parallel frame receiver, the receive end of the shift-register PISO serial link. Accepts a framed, bit-qualified serial stream (`shift_rx_start` marks the first bit of each word) and reassembles `WIDTH`-bit words using a bit counter and a two-state FSM. Completed words go into a single-entry output holding register with a valid/ready handshake. A sticky overflow flag records words dropped under backpressure.

## Interface
- `WIDTH`, default 4: word width in bits; legal range 2..16.
- `MSB_FIRST`, default 1
  - 1: first received bit lands in `dout[WIDTH-1]`. This matches the PISO transmitter.
  - 0: first received bit lands in `dout[0]`.

Ports:
- `shift_reg_clk`  in  1  single clock, rising edge.
- `shift_reg_rst_n`  in  1  reset; asynchronous assert, active-low.
- `shift_rx_sin`  in  1  serial data bit.
- `shift_rx_sin_vld`  in  1  qualifies `shift_rx_sin` for this cycle.
- `shift_rx_start`  in  1  first-bit-of-frame marker; meaningful only when `shift_rx_sin_vld`=1.
- `shift_rx_dout_rdy`  in  1  downstream accepts the word this cycle.
- `shift_rx_ovf_clr`  in  1  clears the sticky overflow flag.
- `shift_rx_dout`  out  WIDTH  assembled word, registered.
- `shift_rx_dout_vld`  out  1  `shift_rx_dout` holds an unconsumed word.
- `shift_rx_busy`  out  1  frame in progress (state SHIFT).
- `shift_rx_ovf`  out  1  sticky: at least one completed word was dropped.

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, width $clog2(WIDTH);
  - FSM with states IDLE and SHIFT.
- Reset: all outputs, `sr`, `cnt` and `shift_rx_dout` clear to 0; state goes to IDLE.
- Bit capture, applied on every accepted bit:
  - `MSB_FIRST`=1: `sr <= {sr[WIDTH-2:0], sin}`.
  - `MSB_FIRST`=0: `sr <= {sin, sr[WIDTH-1:1]}`.
- IDLE:
  - `sin_vld`=1 and `start`=1: capture bit, `cnt <= 1`, go to SHIFT.
  - `sin_vld`=1 and `start`=0: ignore the bit (unframed data).
  - `sin_vld`=0: hold.
- SHIFT:
  - `sin_vld`=0: hold `sr`, `cnt` and state. Gaps of any length are legal.
  - `sin_vld`=1 and `start`=1: resync. Discard the partial word, capture this bit as bit 0, `cnt <= 1`, stay in SHIFT. No overflow is flagged.
  - `sin_vld`=1, `start`=0, `cnt`<WIDTH-1: capture bit, `cnt <= cnt+1`.
  - `sin_vld`=1, `start`=0, `cnt`==WIDTH-1: this is the last bit. Form the word (`sr` with the bit applied), go to IDLE, `cnt <= 0`, then run word delivery.
- Word delivery, when a word completes:
  - Slot free (`dout_vld`=0), or slot being drained this cycle (`dout_vld`=1 and `dout_rdy`=1): load `shift_rx_dout`, set `dout_vld`=1.
  - Slot full and not drained: drop the new word, keep the old word and `dout_vld`, set `shift_rx_ovf`=1.
- Handshake:
  - A transfer occurs on a cycle with `dout_vld`=1 and `dout_rdy`=1.
  - If no word is loaded that same cycle, `dout_vld` clears next edge.
  - `shift_rx_dout` is stable while `dout_vld`=1 and not transferred.
  - `dout_rdy` while `dout_vld`=0 has no effect.
- Overflow flag:
  - Set by a drop. Cleared by `ovf_clr`.
  - Drop and `ovf_clr` on the same cycle: set wins, flag stays 1.
- Busy: `shift_rx_busy` = (state == SHIFT), registered.

## Timing
- Latency: the last bit is sampled at edge N; `dout_vld`=1 and the word are visible after edge N, i.e. in cycle N+1.
- Back-to-back frames: the `start` bit of the next frame may arrive in the cycle right after the last bit. No dead cycle is required.
- Throughput: one word per WIDTH valid bit-cycles when `dout_rdy` is held 1.
- Reset mid-frame: asynchronous clear. The partial word is lost, `dout_vld` drops immediately, and no overflow is flagged.
- Inputs are sampled only at the rising edge. No combinational path from any input to any output.

## Test plan
- Basic frame, WIDTH=4, MSB_FIRST=1, `rdy`=1:
  - Stimulus: bits 1,1,0,1 with `start` on the first bit.
  - Response: `dout`=4'b1101 with `vld`=1 for one cycle, in the cycle after the 4th bit. `busy` high during bits 2-4.
- Gapped input:
  - Stimulus: same frame as the basic test, with `sin_vld`=0 for 3 cycles between bits 2 and 3.
  - Response: still `dout`=4'b1101, one cycle after the last valid bit. No spurious `vld`.
- Backpressure and overflow:
  - Stimulus: `rdy`=0; frames 4'b1010 then 4'b0110.
  - Response: `dout` holds 4'b1010 and `ovf`=1. Then `rdy`=1 drains 1010 and `vld` drops. `ovf_clr` clears `ovf`.
- Resync and unframed bits:
  - Stimulus: 2 bits without `start` while IDLE (ignored). Then `start`+1,0, then `start`+0,0,1,1.
  - Response: single word 4'b0011. `ovf`=0.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 after 2 bits of a frame.
  - Response: all outputs go to 0 immediately. The next full frame 4'b1001 is received correctly.
- Back-to-back with LSB order:
  - Stimulus: MSB_FIRST=0; two consecutive frames, each first bit marked by `start`, with first-received-to-last-received bit orders 1,0,0,0 and 0,1,1,1; no idle cycle between frames; `rdy`=1.
  - Response: `dout`=4'b0001 then 4'b1110 on consecutive word boundaries, 4 cycles apart.
